// File: rtl/myproject_mac_pkg.sv
// Shared types and width helpers for the MAC accumulate/round/saturate stage.
package myproject_mac_pkg;

    // Group sequencing: waiting for a first beat, mid-group, result held.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Accumulator width: enough headroom for N_TERMS products plus the aligned bias.
    function automatic int acc_width(input int prod_w, input int n_terms);
        return prod_w + clog2(n_terms + 1) + 1;
    endfunction

    // Largest value representable in an out_w-bit signed word.
    function automatic longint sat_max(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - 1;
    endfunction

    // Smallest value representable in an out_w-bit signed word.
    function automatic longint sat_min(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/myproject_round_sat.sv
// Combinational round-half-up and clamp from the accumulator grid to the output format.
module myproject_round_sat
    import myproject_mac_pkg::*;
#(
    parameter int ACC_W      = 35,
    parameter int FRAC_SHIFT = 10,
    parameter int OUT_W      = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [OUT_W-1:0] data,
    output logic                    sat
);

    // One guard bit so the rounding add can never wrap.
    localparam int RW = ACC_W + 1;
    localparam logic signed [RW-1:0] SAT_HI = RW'(sat_max(OUT_W));
    localparam logic signed [RW-1:0] SAT_LO = RW'(sat_min(OUT_W));

    logic signed [RW-1:0] acc_ext;
    logic signed [RW-1:0] rounded;

    assign acc_ext = {acc[ACC_W-1], acc};

    // Add half an output LSB, then drop the fractional bits (floor), giving half-up.
    generate
        if (FRAC_SHIFT > 0) begin : g_round
            localparam logic signed [RW-1:0] HALF = RW'(1) <<< (FRAC_SHIFT - 1);
            logic signed [RW-1:0] biased;
            assign biased  = acc_ext + HALF;
            assign rounded = biased >>> FRAC_SHIFT;
        end else begin : g_noround
            assign rounded = acc_ext;
        end
    endgenerate

    // Clip to the signed OUT_W range and flag when clipping happened.
    always_comb begin
        data = rounded[OUT_W-1:0];
        sat  = 1'b0;
        if (rounded > SAT_HI) begin
            data = SAT_HI[OUT_W-1:0];
            sat  = 1'b1;
        end else if (rounded < SAT_LO) begin
            data = SAT_LO[OUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/myproject_mac_accum_sat.sv
// Sums N_TERMS signed products plus an aligned bias per group, rounds and saturates
// the total, and presents one result per group on a valid/ready output.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both high.
// Valid is never withdrawn and payload never changes while valid is high and ready is low.
module myproject_mac_accum_sat
    import myproject_mac_pkg::*;
#(
    parameter int PROD_W     = 30,
    parameter int N_TERMS    = 9,
    parameter int BIAS_W     = 16,
    parameter int BIAS_SHIFT = 10,
    parameter int FRAC_SHIFT = 10,
    parameter int OUT_W      = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    input  logic [BIAS_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat,
    output logic              err_last
);

    localparam int ACC_W = acc_width(PROD_W, N_TERMS);
    localparam int CNT_W = (clog2(N_TERMS + 1) > 0) ? clog2(N_TERMS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  acc;

    logic                     accept;
    logic                     is_final;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_al;
    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W-1:0]  sum;
    logic [OUT_W-1:0]         rs_data;
    logic                     rs_sat;

    // Input side is open except while a result waits on a stalled consumer.
    always_comb begin
        in_ready = 1'b0;
        if (!ap_rst) begin
            case (state)
                IDLE, ACCUM: in_ready = 1'b1;
                HOLD:        in_ready = out_ready;
                default:     in_ready = 1'b0;
            endcase
        end
    end

    assign accept   = in_valid & in_ready;
    // cnt is 0 outside ACCUM, so this also covers a one-term group starting from IDLE/HOLD.
    assign is_final = (cnt == LAST_CNT);

    // Sign-extend everything to ACC_W before adding; a new group starts from the bias.
    assign prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
    assign bias_al  = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias} <<< BIAS_SHIFT;
    assign base     = (state == ACCUM) ? acc : bias_al;
    assign sum      = base + prod_ext;

    myproject_round_sat #(
        .ACC_W      (ACC_W),
        .FRAC_SHIFT (FRAC_SHIFT),
        .OUT_W      (OUT_W)
    ) u_round_sat (
        .acc  (sum),
        .data (rs_data),
        .sat  (rs_sat)
    );

    // Group FSM, beat counter, accumulator and registered result.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            err_last  <= 1'b0;
        end else begin
            err_last <= accept && (in_last != is_final);
            // A consumed result drops valid unless a new result replaces it below.
            if ((state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                acc <= sum;
                if (is_final) begin
                    cnt       <= '0;
                    out_data  <= rs_data;
                    out_sat   <= rs_sat;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end else begin
                    cnt   <= cnt + CNT_W'(1);
                    state <= ACCUM;
                end
            end else if ((state == HOLD) && out_ready) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_myproject_mac_accum_sat.sv
// Bench for the MAC accumulate/round/saturate stage: table vectors, directed
// multi-cycle sequences and randomized groups against an arithmetic model.
module tb_myproject_mac_accum_sat;

    logic        ap_clk;
    logic        ap_rst;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] in_prod;
    logic        in_last;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        err_last;

    int n_vec  = 0;
    int n_miss = 0;
    int err_cnt = 0;
    logic rand_rdy = 1'b0;

    // Expected results as {sat, data}.
    logic [16:0] exp_q[$];

    typedef struct {
        logic signed [15:0] b;
        longint             p0;
        longint             pr;
        logic signed [15:0] ed;
        logic               es;
    } vec_t;

    vec_t tbl[10];

    myproject_mac_accum_sat dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .err_last  (err_last)
    );

    // Clock.
    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact arithmetic, floor((total + half) / 2^10), then clamp.
    function automatic logic [16:0] model(input longint b, input longint s);
        longint tot;
        longint r;
        tot = b * 1024 + s;
        r = (tot + 512) >>> 10;
        if (r > 32767) return {1'b1, 16'h7fff};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(r)};
    endfunction

    // Scoreboard: every output transfer is compared to the oldest expected result.
    always @(negedge ap_clk) begin
        if (!ap_rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("out_data", longint'($signed(out_data)), longint'($signed(e[15:0])));
                check("out_sat", longint'(out_sat), longint'(e[16]));
            end
        end
        if (!ap_rst && err_last) err_cnt = err_cnt + 1;
    end

    // Random back-pressure on the output side when enabled.
    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input longint p, input logic l, input logic [15:0] b);
        int waited;
        in_valid = 1'b1;
        in_prod  = 30'(p);
        in_last  = l;
        bias     = b;
        waited   = 0;
        @(negedge ap_clk);
        while (!in_ready && waited < 200) begin
            waited = waited + 1;
            @(negedge ap_clk);
        end
        if (!in_ready) check("beat_accept_timeout", 0, 1);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic group(input logic [15:0] b, input longint p0, input longint pr, input int last_at);
        for (int i = 1; i <= 9; i++) begin
            beat((i == 1) ? p0 : pr, (i == last_at), b);
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            waited = waited + 1;
            @(negedge ap_clk);
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", longint'(exp_q.size()), 0);
            exp_q.delete();
        end
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        int e0;
        // Reset and idle levels.
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        bias      = '0;
        out_ready = 1'b1;

        tbl[0] = '{16'sd0,  1024,                      1024,      16'sd9,      1'b0};
        tbl[1] = '{16'sd3,  0,                         0,         16'sd3,      1'b0};
        tbl[2] = '{16'sd0,  512,                       0,         16'sd1,      1'b0};
        tbl[3] = '{16'sd0,  -512,                      0,         16'sd0,      1'b0};
        tbl[4] = '{16'sd0,  (longint'(1) << 29) - 1,   (longint'(1) << 29) - 1, 16'sd32767, 1'b1};
        tbl[5] = '{16'sd0,  -(longint'(1) << 29),      -(longint'(1) << 29),    -16'sd32768, 1'b1};
        tbl[6] = '{-16'sd5, 0,                         0,         -16'sd5,     1'b0};
        tbl[7] = '{16'sd0,  32767 * 1024 + 511,        0,         16'sd32767,  1'b0};
        tbl[8] = '{16'sd0,  32767 * 1024 + 512,        0,         16'sd32767,  1'b1};
        tbl[9] = '{16'sd0,  -32768 * 1024 - 513,       0,         -16'sd32768, 1'b1};

        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_sat", longint'(out_sat), 0);
        check("rst_err_last", longint'(err_last), 0);
        check("rst_in_ready", longint'(in_ready), 0);
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(posedge ap_clk);
        #1;

        // Table vectors; test 1 also checks result latency.
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({tbl[i].es, tbl[i].ed});
            group(tbl[i].b, tbl[i].p0, tbl[i].pr, 9);
            if (i == 0) check("latency_out_valid", longint'(out_valid), 1);
            drain();
        end
        check("err_last_clean_groups", longint'(err_cnt), 0);

        // Stalled consumer, then simultaneous result transfer and first beat.
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 16'd9});
        group(16'd0, 1024, 1024, 9);
        for (int k = 0; k < 5; k++) begin
            @(negedge ap_clk);
            check("stall_out_valid", longint'(out_valid), 1);
            check("stall_out_data", longint'($signed(out_data)), 9);
            check("stall_in_ready", longint'(in_ready), 0);
        end
        @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 16'd11});
        beat(1024, 1'b0, 16'd2);
        check("overlap_out_valid_drop", longint'(out_valid), 0);
        check("overlap_consumed", longint'(exp_q.size()), 1);
        for (int i = 2; i <= 9; i++) beat(1024, (i == 9), 16'd2);
        drain();

        // Misplaced in_last: early on beat 5, missing on beat 9.
        e0 = err_cnt;
        exp_q.push_back({1'b0, 16'd19});
        for (int i = 1; i <= 9; i++) begin
            beat(2048, (i == 5), 16'd1);
            if (i == 5) check("err_last_beat5", longint'(err_last), 1);
            if (i == 4 || i == 6) check("err_last_quiet", longint'(err_last), 0);
            if (i == 9) check("err_last_beat9", longint'(err_last), 1);
        end
        drain();
        check("err_last_pulses", longint'(err_cnt - e0), 2);

        // Asynchronous reset mid-group discards the partial sum.
        for (int i = 1; i <= 4; i++) beat(1024, 1'b0, 16'd0);
        #2;
        ap_rst = 1'b1;
        #1;
        check("async_rst_out_data", longint'(out_data), 0);
        check("async_rst_out_valid", longint'(out_valid), 0);
        check("async_rst_in_ready", longint'(in_ready), 0);
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(posedge ap_clk);
        #1;
        exp_q.push_back({1'b0, 16'd9});
        group(16'd0, 1024, 1024, 9);
        drain();

        // Randomized groups with input gaps and output back-pressure.
        e0 = err_cnt;
        rand_rdy = 1'b1;
        for (int g = 0; g < 40; g++) begin
            longint s;
            longint p;
            logic [15:0] b;
            b = 16'($urandom);
            s = 0;
            for (int i = 1; i <= 9; i++) begin
                p = longint'($signed(30'($urandom))) >>> $urandom_range(0, 22);
                s = s + p;
                if (i == 1) exp_q.push_back(16'd0);
                if (i == 9) begin
                    exp_q.delete(exp_q.size() - 1);
                    exp_q.push_back(model(longint'($signed(b)), s));
                end
                repeat ($urandom_range(0, 2)) begin
                    @(posedge ap_clk);
                    #1;
                end
                beat(p, (i == 9), b);
            end
        end
        drain();
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        check("err_last_random", longint'(err_cnt - e0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
